// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the control unit and seq_alu.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [4:0]           op;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   C;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;

    modport master (
        output start, op, A, B,
        input  C, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, A, B,
        output C, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus WIDTH-iteration
// signed shift-add multiply and restoring divide.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | take operand magnitudes and signs, arm the iteration counter
// RUN   | one multiply/divide iteration per cycle
// FIX   | apply result signs, write C
// DONE  | done pulse; a new start is accepted here as well
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHL  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_NEG  = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 a_neg_q, b_neg_q;
    logic [WIDTH-1:0]     m_q;       // multiplicand (MUL) or divisor (DIV) magnitude
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   c_q;
    logic                 dbz_q;

    logic                 accept, is_long;
    logic                 busy_c, done_c;
    logic [WIDTH-1:0]     sc_res;
    logic [SHW-1:0]       amt;
    logic [2*WIDTH-1:0]   dbl, ror_t, rol_t;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       r_sh;
    logic [WIDTH+1:0]     diff;
    logic [2*WIDTH-1:0]   prod, mul_res, div_res;
    logic [WIDTH-1:0]     quot, rem;

    assign accept  = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    assign is_long = (bus.op == OP_MUL) || (bus.op == OP_DIV);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = is_long ? S_LOAD : S_DONE;
            end
            S_LOAD: begin
                busy_c  = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                busy_c = 1'b1;
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                busy_c  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = accept ? (is_long ? S_LOAD : S_DONE) : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle result straight from the live operands; rotates use a doubled word
    always_comb begin
        amt    = bus.A[SHW-1:0];
        dbl    = {bus.B, bus.B};
        ror_t  = dbl >> amt;
        rol_t  = dbl << amt;
        sc_res = '0;
        case (bus.op)
            OP_ADD:  sc_res = bus.A + bus.B;
            OP_SUB:  sc_res = bus.A - bus.B;
            OP_SHR:  sc_res = bus.B >> amt;
            OP_SHL:  sc_res = bus.B << amt;
            OP_SHRA: sc_res = $signed(bus.B) >>> amt;
            OP_ROR:  sc_res = ror_t[WIDTH-1:0];
            OP_ROL:  sc_res = rol_t[2*WIDTH-1:WIDTH];
            OP_AND:  sc_res = bus.A & bus.B;
            OP_OR:   sc_res = bus.A | bus.B;
            OP_NEG:  sc_res = -bus.B;
            OP_NOT:  sc_res = ~bus.B;
            default: sc_res = '0;
        endcase
    end

    // Iteration arithmetic and sign fix-up for the long ops
    always_comb begin
        a_mag   = a_q[WIDTH-1] ? -a_q : a_q;
        b_mag   = b_q[WIDTH-1] ? -b_q : b_q;
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        r_sh    = {hi_q, lo_q[WIDTH-1]};
        diff    = {1'b0, r_sh} - {2'b00, m_q};
        prod    = {hi_q, lo_q};
        mul_res = ((a_neg_q ^ b_neg_q) && (prod != '0)) ? -prod : prod;
        quot    = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
        rem     = a_neg_q ? -hi_q : hi_q;
        // A zero divisor leaves the dividend in the remainder and all ones in
        // the quotient; force the unsigned form so the sign fix cannot disturb it.
        div_res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quot};
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q  <= bus.op;
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        dbz_q <= 1'b0;
                        if (!is_long) c_q <= {{WIDTH{1'b0}}, sc_res};
                    end
                end
                S_LOAD: begin
                    a_neg_q <= a_q[WIDTH-1];
                    b_neg_q <= b_q[WIDTH-1];
                    hi_q    <= '0;
                    cnt_q   <= CW'(WIDTH);
                    if (op_q == OP_MUL) begin
                        m_q  <= a_mag;
                        lo_q <= b_mag;
                    end else begin
                        m_q  <= b_mag;
                        lo_q <= a_mag;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (op_q == OP_MUL) begin
                        {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
                    end else if (!diff[WIDTH+1]) begin
                        hi_q <= diff[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_q <= r_sh[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (op_q == OP_MUL) begin
                        c_q <= mul_res;
                    end else begin
                        c_q   <= div_res;
                        dbz_q <= (b_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.C           = c_q;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32.
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_c;
        logic        exp_dbz;
        int          exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one op from an idle unit; returns busy-cycle count, C and dbz in the done cycle.
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output logic [63:0] c, output logic dbz,
                          output logic c_stable);
        logic [63:0] c_prev;
        int guard;
        @(negedge clk);
        c_prev   = bus.C;
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        nbusy    = 0;
        guard    = 0;
        c_stable = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.busy) nbusy++;
            if (bus.C !== c_prev) c_stable = 1'b0;
            guard++;
            if (guard > 100) begin
                total++;
                bad++;
                $display("FAIL timeout waiting for done op=%b", o);
                break;
            end
        end
        c   = bus.C;
        dbz = bus.div_by_zero;
    endtask

    function automatic vec_t mk(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] c, input logic dbz, input int nb);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp_c = c; v.exp_dbz = dbz; v.exp_busy = nb;
        return v;
    endfunction

    initial begin
        int          nb;
        logic [63:0] c;
        logic        dbz, stable;
        int          seen;

        vecs.push_back(mk(5'b00000, 32'd5,        32'd7,        64'h0000_0000_0000_000C, 1'b0, 0));
        vecs.push_back(mk(5'b00001, 32'd3,        32'd5,        64'h0000_0000_FFFF_FFFE, 1'b0, 0));
        vecs.push_back(mk(5'b00000, 32'hFFFFFFFF, 32'd1,        64'h0,                   1'b0, 0));
        vecs.push_back(mk(5'b00010, 32'hFFFFFFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 34));
        vecs.push_back(mk(5'b00010, 32'h80000000, 32'h80000000, 64'h4000_0000_0000_0000, 1'b0, 34));
        vecs.push_back(mk(5'b00010, 32'd0,        32'hFFFFFFFB, 64'h0,                   1'b0, 34));
        vecs.push_back(mk(5'b00010, 32'd6,        32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 34));
        vecs.push_back(mk(5'b00011, 32'hFFFFFFEF, 32'd5,        64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 34));
        vecs.push_back(mk(5'b00011, 32'h80000000, 32'hFFFFFFFF, 64'h0000_0000_8000_0000, 1'b0, 34));
        vecs.push_back(mk(5'b00011, 32'd17,       32'hFFFFFFFB, 64'h0000_0002_FFFF_FFFD, 1'b0, 34));
        vecs.push_back(mk(5'b00011, 32'd100,      32'd7,        64'h0000_0002_0000_000E, 1'b0, 34));
        vecs.push_back(mk(5'b00011, 32'd42,       32'd0,        64'h0000_002A_FFFF_FFFF, 1'b1, 34));
        vecs.push_back(mk(5'b00001, 32'd9,        32'd4,        64'h0000_0000_0000_0005, 1'b0, 0));
        vecs.push_back(mk(5'b00100, 32'd4,        32'h80000010, 64'h0000_0000_0800_0001, 1'b0, 0));
        vecs.push_back(mk(5'b00101, 32'hFFFFFFE3, 32'd1,        64'h0000_0000_0000_0008, 1'b0, 0));
        vecs.push_back(mk(5'b00110, 32'd4,        32'h80000010, 64'h0000_0000_F800_0001, 1'b0, 0));
        vecs.push_back(mk(5'b00111, 32'd1,        32'd1,        64'h0000_0000_8000_0000, 1'b0, 0));
        vecs.push_back(mk(5'b01000, 32'd0,        32'h12345678, 64'h0000_0000_1234_5678, 1'b0, 0));
        vecs.push_back(mk(5'b01000, 32'h24,       32'h12345678, 64'h0000_0000_2345_6781, 1'b0, 0));
        vecs.push_back(mk(5'b00100, 32'd0,        32'hA5A5A5A5, 64'h0000_0000_A5A5_A5A5, 1'b0, 0));
        vecs.push_back(mk(5'b01001, 32'hF0F0F0F0, 32'hFF00FF00, 64'h0000_0000_F000_F000, 1'b0, 0));
        vecs.push_back(mk(5'b01010, 32'hF0F0F0F0, 32'hFF00FF00, 64'h0000_0000_FFF0_FFF0, 1'b0, 0));
        vecs.push_back(mk(5'b01011, 32'd0,        32'd1,        64'h0000_0000_FFFF_FFFF, 1'b0, 0));
        vecs.push_back(mk(5'b01100, 32'd0,        32'h0F0F0F0F, 64'h0000_0000_F0F0_F0F0, 1'b0, 0));
        vecs.push_back(mk(5'b11111, 32'd3,        32'd9,        64'h0,                   1'b0, 0));
        vecs.push_back(mk(5'b01101, 32'd3,        32'd9,        64'h0,                   1'b0, 0));

        bus.start = 1'b0;
        bus.op    = '0;
        bus.A     = '0;
        bus.B     = '0;

        repeat (2) @(negedge clk);
        check("reset C", bus.C, 64'h0);
        check("reset busy", {63'h0, bus.busy}, 64'h0);
        check("reset done", {63'h0, bus.done}, 64'h0);
        check("reset dbz", {63'h0, bus.div_by_zero}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb, c, dbz, stable);
            check($sformatf("v%0d op=%b C", i, vecs[i].op), c, vecs[i].exp_c);
            check($sformatf("v%0d dbz", i), {63'h0, dbz}, {63'h0, vecs[i].exp_dbz});
            check($sformatf("v%0d busy cycles", i), 64'(nb), 64'(vecs[i].exp_busy));
            if (vecs[i].exp_busy > 0)
                check($sformatf("v%0d C held while busy", i), {63'h0, stable}, 64'h1);
        end

        // start held high through a DIV while op/operands change; accepted only in DONE
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 5'b00011;
        bus.A     = 32'hFFFFFFEF;
        bus.B     = 32'd5;
        @(posedge clk);
        #1;
        bus.op = 5'b00000;
        bus.A  = 32'd1;
        bus.B  = 32'd2;
        nb     = 0;
        seen   = 0;
        stable = 1'b1;
        c      = bus.C;
        for (int k = 0; k < 60 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            else begin
                if (bus.busy) nb++;
                if (bus.C !== c) stable = 1'b0;
            end
        end
        check("held-start DIV done seen", 64'(seen), 64'd1);
        check("held-start DIV busy cycles", 64'(nb), 64'd34);
        check("held-start C stable", {63'h0, stable}, 64'h1);
        check("held-start DIV C", bus.C, 64'hFFFF_FFFE_FFFF_FFFD);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("back-to-back ADD done", {63'h0, bus.done}, 64'h1);
        check("back-to-back ADD C", bus.C, 64'h3);
        @(negedge clk);
        check("idle after b2b done", {62'h0, bus.busy, bus.done}, 64'h0);

        // reset in the middle of a MUL abandons it
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 5'b00010;
        bus.A     = 32'hFFFFFFFD;
        bus.B     = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid-run reset C", bus.C, 64'h0);
        check("mid-run reset busy", {63'h0, bus.busy}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("no done after reset", 64'(seen), 64'd0);
        check("C still zero after reset", bus.C, 64'h0);
        run_op(5'b00000, 32'd5, 32'd7, nb, c, dbz, stable);
        check("post-reset ADD C", c, 64'hC);
        check("post-reset ADD busy cycles", 64'(nb), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
